// File: rtl/store_queue_pkg.sv
// Shared types for the commit-side store queue; the address width matches the
// CPU data-memory array.
package store_queue_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int SQ_DATA_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic [MEM_ADDR_W-1:0] addr;
        logic [SQ_DATA_W-1:0]  data;
    } store_entry_t;

endpackage

// File: rtl/store_queue_fwd_select.sv
// Youngest-first address match over the queue entries for store-to-load forwarding.
module store_queue_fwd_select
    import store_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  store_entry_t          entries [DEPTH],
    input  logic [PTR_W-1:0]      tail,
    input  logic [MEM_ADDR_W-1:0] ld_addr,
    output logic                  hit,
    output logic [SQ_DATA_W-1:0]  data
);

    logic [PTR_W-1:0] idx;

    // Valid entries are contiguous behind tail, so the first match walking
    // backwards from tail-1 is the youngest store to that address.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = tail - PTR_W'(k);
            if (!hit && entries[idx].valid && entries[idx].addr == ld_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// Commit-side store queue: in-order drain to memory over req/ack, with
// forwarding of committed-but-undrained stores to later loads.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = SQ_DATA_W
) (
    input  logic                       clk,
    input  logic                       RSTN_N,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    store_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic [0:0]       state;
    logic             push_fire;
    logic             pop_fire;

    // No full-queue bypass: a pop on the same edge does not open a slot early.
    assign push_ready = (count != CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = (state == REQ) && mem_ack;
    assign head_nxt   = head + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!RSTN_N) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (push_fire) begin
                entries[tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                tail          <= tail + PTR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        mem_addr  <= entries[head].addr;
                        mem_wdata <= entries[head].data;
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                default: begin
                    if (mem_ack) begin
                        entries[head].valid <= 1'b0;
                        head                <= head_nxt;
                        // The next entry is already resident, so keep writing back-to-back.
                        if (count > CNT_W'(1)) begin
                            mem_addr  <= entries[head_nxt].addr;
                            mem_wdata <= entries[head_nxt].data;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
            endcase

            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    store_queue_fwd_select #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (entries),
        .tail    (tail),
        .ld_addr (ld_addr),
        .hit     (ld_hit),
        .data    (ld_data)
    );

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: cycle table plus hand sequences, with a
// push-order scoreboard checking every acknowledged memory write.
module tb_store_queue;

    logic        clk = 1'b0;
    logic        RSTN_N;
    logic        push_valid;
    logic        push_ready;
    logic [9:0]  push_addr;
    logic [31:0] push_data;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [9:0]  ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic [3:0]  count;
    logic        empty;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        pv;
        logic [9:0]  pa;
        logic [31:0] pd;
        logic        ack;
        logic [9:0]  la;
        int          cnt;
        logic        rdy;
        logic        req;
        logic [9:0]  maddr;
        logic [31:0] wd;
        logic        hit;
        logic [31:0] ld;
    } vec_t;

    vec_t        vec [10];
    logic [41:0] sb_q [$];

    store_queue dut (
        .clk        (clk),
        .RSTN_N     (RSTN_N),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so at negedge they show what the next edge samples.
    always @(negedge clk) begin
        logic [41:0] exp_w;
        if (!RSTN_N) begin
            sb_q.delete();
        end else begin
            if (mem_req && mem_ack) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_write", {22'd0, mem_addr}, 32'h3ff);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("sb_addr", {22'd0, mem_addr}, {22'd0, exp_w[41:32]});
                    chk("sb_data", mem_wdata, exp_w[31:0]);
                end
            end
            if (push_valid && push_ready) sb_q.push_back({push_addr, push_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int guard;
        logic acc;

        vec[0] = '{1'b1, 10'd5, 32'h11, 1'b0, 10'd5, 1, 1'b1, 1'b0, 10'd0, 32'h0,  1'b1, 32'h11};
        vec[1] = '{1'b0, 10'd0, 32'h0,  1'b0, 10'd5, 1, 1'b1, 1'b1, 10'd5, 32'h11, 1'b1, 32'h11};
        vec[2] = '{1'b0, 10'd0, 32'h0,  1'b0, 10'd5, 1, 1'b1, 1'b1, 10'd5, 32'h11, 1'b1, 32'h11};
        vec[3] = '{1'b0, 10'd0, 32'h0,  1'b1, 10'd5, 0, 1'b1, 1'b0, 10'd5, 32'h11, 1'b0, 32'h0};
        vec[4] = '{1'b1, 10'd7, 32'h1,  1'b0, 10'd7, 1, 1'b1, 1'b0, 10'd5, 32'h11, 1'b1, 32'h1};
        vec[5] = '{1'b1, 10'd7, 32'h2,  1'b0, 10'd7, 2, 1'b1, 1'b1, 10'd7, 32'h1,  1'b1, 32'h2};
        vec[6] = '{1'b0, 10'd0, 32'h0,  1'b0, 10'd8, 2, 1'b1, 1'b1, 10'd7, 32'h1,  1'b0, 32'h0};
        vec[7] = '{1'b0, 10'd0, 32'h0,  1'b1, 10'd7, 1, 1'b1, 1'b1, 10'd7, 32'h2,  1'b1, 32'h2};
        vec[8] = '{1'b0, 10'd0, 32'h0,  1'b1, 10'd7, 0, 1'b1, 1'b0, 10'd7, 32'h2,  1'b0, 32'h0};
        vec[9] = '{1'b0, 10'd0, 32'h0,  1'b1, 10'd7, 0, 1'b1, 1'b0, 10'd7, 32'h2,  1'b0, 32'h0};

        // Reset with a push presented: nothing may be accepted.
        RSTN_N = 1'b0; push_valid = 1'b1; push_addr = 10'd3; push_data = 32'h33;
        mem_ack = 1'b0; ld_addr = 10'd3;
        step();
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, push_ready}, 32'd1);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_hit", {31'd0, ld_hit}, 32'd0);
        chk("rst_ldata", ld_data, 32'd0);
        chk("rst_maddr", {22'd0, mem_addr}, 32'd0);
        RSTN_N = 1'b1; push_valid = 1'b0;

        // Single store and forwarding, one row per clock edge.
        for (int r = 0; r < 10; r++) begin
            push_valid = vec[r].pv; push_addr = vec[r].pa; push_data = vec[r].pd;
            mem_ack = vec[r].ack; ld_addr = vec[r].la;
            step();
            chk($sformatf("row%0d_count", r), {28'd0, count}, vec[r].cnt);
            chk($sformatf("row%0d_empty", r), {31'd0, empty}, {31'd0, vec[r].cnt == 0});
            chk($sformatf("row%0d_ready", r), {31'd0, push_ready}, {31'd0, vec[r].rdy});
            chk($sformatf("row%0d_req", r), {31'd0, mem_req}, {31'd0, vec[r].req});
            chk($sformatf("row%0d_maddr", r), {22'd0, mem_addr}, {22'd0, vec[r].maddr});
            chk($sformatf("row%0d_wdata", r), mem_wdata, vec[r].wd);
            chk($sformatf("row%0d_hit", r), {31'd0, ld_hit}, {31'd0, vec[r].hit});
            chk($sformatf("row%0d_ldata", r), ld_data, vec[r].ld);
        end
        push_valid = 1'b0; mem_ack = 1'b0;

        // Back-to-back drain of three stores.
        for (int k = 1; k <= 3; k++) begin
            push_valid = 1'b1; push_addr = 10'(k); push_data = 32'(k + 16);
            step();
        end
        push_valid = 1'b0;
        chk("b2b_req0", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr0", {22'd0, mem_addr}, 32'd1);
        mem_ack = 1'b1;
        step();
        chk("b2b_req1", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr1", {22'd0, mem_addr}, 32'd2);
        step();
        chk("b2b_req2", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr2", {22'd0, mem_addr}, 32'd3);
        step();
        chk("b2b_req_end", {31'd0, mem_req}, 32'd0);
        chk("b2b_empty", {31'd0, empty}, 32'd1);
        mem_ack = 1'b0;

        // Fill to capacity, reject a ninth push, then release one slot.
        for (int k = 0; k < 8; k++) begin
            push_valid = 1'b1; push_addr = 10'(20 + k); push_data = 32'(200 + k);
            step();
        end
        chk("full_count", {28'd0, count}, 32'd8);
        chk("full_ready", {31'd0, push_ready}, 32'd0);
        push_addr = 10'd99; push_data = 32'd999;
        step();
        chk("full_reject_count", {28'd0, count}, 32'd8);
        push_valid = 1'b0; mem_ack = 1'b1;
        step();
        chk("full_pop_count", {28'd0, count}, 32'd7);
        chk("full_pop_ready", {31'd0, push_ready}, 32'd1);
        step(); step(); step();
        chk("drain_to4", {28'd0, count}, 32'd4);
        push_valid = 1'b1; push_addr = 10'd30; push_data = 32'd230;
        step();
        chk("pushpop_count", {28'd0, count}, 32'd4);
        chk("pushpop_req", {31'd0, mem_req}, 32'd1);
        chk("pushpop_addr", {22'd0, mem_addr}, 32'd25);
        push_valid = 1'b0; mem_ack = 1'b0;

        // Stream 20 stores with random acks; the scoreboard checks write order.
        i = 0;
        guard = 0;
        while (i < 20 && guard < 2000) begin
            push_valid = 1'b1; push_addr = 10'(i); push_data = 32'(100 + i);
            mem_ack = 1'($urandom_range(0, 1));
            acc = push_ready;
            step();
            if (acc) i++;
            guard++;
        end
        chk("stream_pushed", i, 32'd20);
        push_valid = 1'b0; mem_ack = 1'b1;
        guard = 0;
        while (!empty && guard < 200) begin
            step();
            guard++;
        end
        step();
        mem_ack = 1'b0;
        chk("stream_empty", {31'd0, empty}, 32'd1);
        chk("stream_req_idle", {31'd0, mem_req}, 32'd0);
        chk("stream_sb_left", sb_q.size(), 32'd0);

        // Reset while a request is outstanding.
        push_valid = 1'b1; push_addr = 10'd50; push_data = 32'd500;
        step();
        push_addr = 10'd51; push_data = 32'd501;
        step();
        push_valid = 1'b0;
        step();
        chk("mid_req_before", {31'd0, mem_req}, 32'd1);
        RSTN_N = 1'b0; ld_addr = 10'd50;
        step();
        chk("mid_req", {31'd0, mem_req}, 32'd0);
        chk("mid_count", {28'd0, count}, 32'd0);
        chk("mid_empty", {31'd0, empty}, 32'd1);
        chk("mid_hit", {31'd0, ld_hit}, 32'd0);
        chk("mid_maddr", {22'd0, mem_addr}, 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        RSTN_N = 1'b1;
        step();
        chk("mid_post_req", {31'd0, mem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
